mm2s_reader: RTL and testbench
==============================

# mm2s_reader

Memory-mapped-to-stream DMA reader: accepts a (base address, word count) command, issues AXI-Lite reads against DDR and emits the returned words as an AXI-Stream vector with `last` on the final word. It feeds the `fl_vadd` X/Y vector inputs, one instance per operand. It is the read-side counterpart of `s2mm`, which turns the adder's output stream back into DDR writes.

## Interface
- `ADDR_WIDTH`, 32: AXI-Lite read address width.
- `DATA_WIDTH`, 32: word width on AXI-Lite R channel and stream; multiple of 8.
- `LEN_WIDTH`, 16: width of the word-count field.
- `FIFO_DEPTH`, 4: return-data buffer depth and maximum outstanding reads; power of 2, ≥2.

- `clk`  in  1  clock; everything on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_addr`  in  ADDR_WIDTH  byte base address, word-aligned.
- `cmd_len`  in  LEN_WIDTH  number of words to read.
- `cmd_valid`  in  1  command valid.
- `cmd_ready`  out  1  command accepted when both high.
- `raddr`  out  ADDR_WIDTH  AR address.
- `arvalid` / `arready`  out / in  1  AR handshake.
- `rdata`  in  DATA_WIDTH  read data.
- `rresp`  in  2  read response; nonzero = error.
- `rvalid` / `rready`  in / out  1  R handshake.
- `m_data`  out  DATA_WIDTH  stream data.
- `m_valid` / `m_ready`  out / in  1  stream handshake.
- `m_last`  out  1  final word of the vector.
- `busy`  out  1  high from command accept until `done`.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky; set on any nonzero `rresp`, cleared on the next command accept.

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch the address into `issue_addr` and `cmd_len` into `issue_left` and `recv_left`, then clear `err`.
  - `cmd_len`=0: go to FLUSH with no reads issued.
  - Otherwise go to RUN.
- RUN, AR issue:
  - `arvalid`=1 while `issue_left`>0 and `outstanding + fifo_count < FIFO_DEPTH`.
  - Once `arvalid` is asserted, hold it and `raddr` stable until `arready`.
  - On handshake: `issue_addr += DATA_WIDTH/8` (modulo 2^ADDR_WIDTH, wraps silently), `issue_left--`, `outstanding++`.
- RUN, R accept:
  - `rready`=1 throughout RUN. The credit rule guarantees the FIFO always has space.
  - On handshake: push `rdata` into the FIFO, `outstanding--`, `recv_left--`.
  - The word pushed when `recv_left`=1 is tagged last.
  - When AR and R handshakes fall in the same cycle, `outstanding` is unchanged.
- FIFO output drives `m_data`, `m_valid` and `m_last` (the tag). A pop happens on `m_valid && m_ready`.
- Transition to FLUSH on the handshake of the tagged-last word.
- FLUSH: one cycle. `done`=1, then IDLE. `busy` is high in RUN and FLUSH.
- Responses are matched in order; no IDs.
- `rresp`≠0: data is still forwarded unchanged and `err` is set.

## Timing
- Reset values:
  - `cmd_ready`=0 during reset, 1 in the first cycle after reset.
  - `arvalid`, `rready`, `m_valid`, `m_last`, `busy`, `done`, `err` are 0.
  - `raddr` is 0.
  - FIFO and all counters are cleared.
- Reset mid-operation discards all state. Responses still in flight are the system's responsibility (the interconnect is reset alongside).
- First `arvalid`: the cycle after the command handshake.
- Read data to stream: `m_valid` is asserted the cycle after the R handshake (registered FIFO write, show-ahead read).
- Sustained throughput is 1 word/cycle when `arready`, `rvalid` and `m_ready` are continuously high and the memory latency is < FIFO_DEPTH cycles.
- `m_data` and `m_last` are stable while `m_valid && !m_ready`.
- `done`: the cycle after the last-word stream handshake.
- `cmd_ready`: the cycle after `done`.
- `cmd_len`=0: `done` is asserted the cycle after the command handshake.
- Backpressure: with `m_ready`=0, at most FIFO_DEPTH words are in flight plus buffered; further AR is stalled and no R beat is dropped.

## Configuration
- `MM2S_ERR_ABORT_EN` defined:
  - After the first nonzero `rresp`, `issue_left` is forced to 0 and no new AR is issued.
  - Outstanding responses are still accepted and forwarded.
  - The last word received when `outstanding` reaches 0 is tagged `m_last`. The stream is therefore truncated, not padded.
  - `done` and `err` are asserted as usual.
- `MM2S_ERR_ABORT_EN` undefined: errors only set `err`, and exactly `cmd_len` words are always delivered.

## Test plan
- **Basic read:** cmd base 0x100, len 4; memory holds 0xA0..0xA3 with 1-cycle latency, `m_ready`=1.
  - `raddr` sequence 0x100, 0x104, 0x108, 0x10C.
  - Stream 0xA0..0xA3 with `m_last` only on 0xA3.
  - `done` is asserted one cycle after the last handshake.
- **Backpressure:** len 16 with `m_ready` toggling 0/1 every 3 cycles and memory latency 6.
  - All 16 words arrive in order.
  - `outstanding + fifo_count` never exceeds 4.
  - `raddr` is stable while `arvalid && !arready`.
- **Zero length:** cmd len 0.
  - No `arvalid` is issued.
  - `done` is asserted the cycle after accept; `cmd_ready` returns to 1 the following cycle.
- **Address wrap:** `ADDR_WIDTH`=8, base 0xF8, len 3.
  - Addresses 0xF8, 0xFC, 0x00.
- **Error:** len 8, `rresp`=2 on word 3.
  - Without the macro: 8 words are delivered and `err`=1 after `done`.
  - With `MM2S_ERR_ABORT_EN`: no AR after that response, and `m_last` is on the last outstanding word.
  - In both cases `err` clears on the next command accept.
- **Reset mid-run:** assert `rst` during word 5 of a 10-word read.
  - The next cycle shows all outputs at reset values.
  - A new command len 2 completes normally.

Source files
------------

// File: rtl/mm2s_reader.sv
// mm2s_reader: memory-mapped to stream DMA reader.
// Takes a (base address, word count) command, issues in-order AXI-Lite reads and
// forwards the returned words as a stream, tagging the final word with m_last.
// Outstanding reads plus buffered words never exceed FIFO_DEPTH, so a returned
// beat always finds room in the buffer.
//
// Handshake rule, used on every channel: a transfer happens on a rising edge
// where valid and ready are both high. Once valid is raised, the payload holds
// until that transfer.
//
// Optional feature: define MM2S_ERR_ABORT_EN to stop issuing reads after the
// first error response and end the stream on the last outstanding word.
module mm2s_reader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            dbg_state
);

    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam int BYTES = DATA_WIDTH / 8;
    localparam logic [CW:0] DEPTH_CNT = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [LEN_WIDTH-1:0]  issue_left;
    logic [LEN_WIDTH-1:0]  issue_left_n;
    logic [LEN_WIDTH-1:0]  recv_left;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         outstanding_n;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         fifo_count_n;
    logic [PW:0]           wr_ptr;
    logic [PW:0]           rd_ptr;
    logic [DATA_WIDTH:0]   fifo_mem [FIFO_DEPTH];
    logic [DATA_WIDTH:0]   fifo_head;

    logic ar_hs;
    logic r_hs;
    logic m_hs;
    logic cmd_hs;
    logic r_err;
    logic aborting;
    logic credit_ok;
    logic arvalid_n;
    logic tag_last;

    assign ar_hs  = arvalid & arready;
    assign r_hs   = rvalid & rready;
    assign m_hs   = m_valid & m_ready;
    assign cmd_hs = cmd_valid & cmd_ready;
    assign r_err  = r_hs & (rresp != 2'b00);

`ifdef MM2S_ERR_ABORT_EN
    // An error seen earlier or on this beat stops further address issue.
    assign aborting = err | r_err;
`else
    assign aborting = 1'b0;
`endif

    // Show-ahead buffer: head entry is presented directly, tag bit is m_last.
    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_head  = fifo_mem[rd_ptr[PW-1:0]];
    assign m_valid    = (fifo_count != '0);
    assign m_data     = fifo_head[DATA_WIDTH-1:0];
    assign m_last     = m_valid & fifo_head[DATA_WIDTH];
    assign raddr      = issue_addr;
    assign dbg_state  = state;

    // Next-cycle counters, AR credit decision and last-word tagging.
    always_comb begin
        outstanding_n = outstanding;
        if (ar_hs && !r_hs) begin
            outstanding_n = outstanding + CW'(1);
        end else if (!ar_hs && r_hs) begin
            outstanding_n = outstanding - CW'(1);
        end

        fifo_count_n = fifo_count;
        if (r_hs && !m_hs) begin
            fifo_count_n = fifo_count + CW'(1);
        end else if (!r_hs && m_hs) begin
            fifo_count_n = fifo_count - CW'(1);
        end

        issue_left_n = issue_left;
        if (aborting) begin
            issue_left_n = '0;
        end else if (ar_hs && (issue_left != '0)) begin
            issue_left_n = issue_left - LEN_WIDTH'(1);
        end

        // Sum of in-flight and buffered words bounds the buffer occupancy.
        credit_ok = ({1'b0, outstanding_n} + {1'b0, fifo_count_n}) < DEPTH_CNT;
        // A pending request is held; a new one needs work left and credit.
        arvalid_n = (arvalid && !arready) || ((issue_left_n != '0) && credit_ok);

        // Final word: either the last of the command, or (after an abort) the
        // beat that drains the last outstanding read with no request pending.
        tag_last = (recv_left == LEN_WIDTH'(1)) ||
                   (aborting && (outstanding_n == '0) && !(arvalid && !arready));
    end

    // Buffer storage, written on each accepted read beat.
    always_ff @(posedge clk) begin
        if (r_hs) begin
            fifo_mem[wr_ptr[PW-1:0]] <= {tag_last, rdata};
        end
    end

    // Control FSM, counters and buffer pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cmd_ready   <= 1'b0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            issue_addr  <= '0;
            issue_left  <= '0;
            recv_left   <= '0;
            outstanding <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            done <= 1'b0;
            if (r_hs) begin
                wr_ptr <= wr_ptr + (PW+1)'(1);
            end
            if (m_hs) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
            end

            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_hs) begin
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                        err         <= 1'b0;
                        issue_addr  <= cmd_addr;
                        issue_left  <= cmd_len;
                        recv_left   <= cmd_len;
                        outstanding <= '0;
                        if (cmd_len == '0) begin
                            state <= S_FLUSH;
                            done  <= 1'b1;
                        end else begin
                            state   <= S_RUN;
                            arvalid <= 1'b1;
                            rready  <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    arvalid     <= arvalid_n;
                    issue_left  <= issue_left_n;
                    outstanding <= outstanding_n;
                    if (ar_hs) begin
                        issue_addr <= issue_addr + ADDR_WIDTH'(BYTES);
                    end
                    if (r_hs) begin
                        err <= err | r_err;
                        if (recv_left != '0) begin
                            recv_left <= recv_left - LEN_WIDTH'(1);
                        end
                    end
                    if (m_hs && m_last) begin
                        state   <= S_FLUSH;
                        done    <= 1'b1;
                        arvalid <= 1'b0;
                        rready  <= 1'b0;
                    end
                end

                S_FLUSH: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm2s_reader.sv
// Bench for mm2s_reader: table of commands run against a latency-configurable
// memory responder, scoreboard on the stream, plus hand-written sequences for
// address wrap (8-bit address instance) and reset in the middle of a read.
module tb_mm2s_reader;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 16;
    localparam int FD = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- main instance ----------------
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] raddr;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    dbg_state;

    mm2s_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .raddr(raddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
    );

    // ---------------- 8-bit address instance (wrap) ----------------
    logic [7:0]    cmd8_addr;
    logic [LW-1:0] cmd8_len;
    logic          cmd8_valid;
    logic          cmd8_ready;
    logic [7:0]    raddr8;
    logic          arvalid8;
    logic          arready8;
    logic [DW-1:0] rdata8;
    logic [1:0]    rresp8;
    logic          rvalid8;
    logic          rready8;
    logic [DW-1:0] m_data8;
    logic          m_valid8;
    logic          m_ready8;
    logic          m_last8;
    logic          busy8;
    logic          done8;
    logic          err8;
    logic [1:0]    dbg_state8;

    mm2s_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .FIFO_DEPTH(FD)) dut8 (
        .clk(clk), .rst(rst),
        .cmd_addr(cmd8_addr), .cmd_len(cmd8_len), .cmd_valid(cmd8_valid), .cmd_ready(cmd8_ready),
        .raddr(raddr8), .arvalid(arvalid8), .arready(arready8),
        .rdata(rdata8), .rresp(rresp8), .rvalid(rvalid8), .rready(rready8),
        .m_data(m_data8), .m_valid(m_valid8), .m_ready(m_ready8), .m_last(m_last8),
        .busy(busy8), .done(done8), .err(err8), .dbg_state(dbg_state8)
    );

    // ---------------- bench state ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } rd_t;

    typedef struct {
        logic [31:0] base;
        int          len;
        int          lat;
        bit          mr_toggle;
        bit          ar_rand;
        int          err_word;
        int          exp_words;
        bit          exp_err;
        logic [31:0] exp_last;
    } vec_t;

    rd_t           pend_q[$];
    logic [DW-1:0] exp_q[$];
    logic [31:0]   addr_log[$];
    logic [7:0]    log8[$];
    logic [7:0]    d8[$];
    logic          l8[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    bit mr_toggle = 0;
    bit ar_rand = 0;
    int err_word = -1;
    int issued = 0;
    int streamed = 0;
    int resp_idx = 0;
    bit err_seen = 0;
    int accept_cyc = -10;
    int done_cyc = -10;
    int cur_len = 0;
    bit got_accept = 0;
    bit got_accept8 = 0;
    bit prev_ar_pend = 0;
    logic [31:0] prev_raddr = '0;
    logic [31:0] last_data = '0;
    bit nxt8_v = 0;
    logic [7:0] nxt8_a = '0;

    // Memory contents: 0xA0 at 0x100, incrementing per word.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hA0 + ((a - 32'h100) >> 2);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: record handshakes of the coming edge, advance, check, drive.
    task automatic tick();
        bit c_hs, ar_hs, r_hs, m_hs, ar8, m8;
        logic [DW-1:0] e;
        if (!rst) begin
            c_hs  = cmd_valid && cmd_ready;
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            m_hs  = m_valid && m_ready;
            if (c_hs) begin
                got_accept = 1;
                accept_cyc = cyc;
                cur_len    = int'(cmd_len);
                issued     = 0;
                streamed   = 0;
                resp_idx   = 0;
                err_seen   = 0;
                last_data  = '0;
                addr_log.delete();
                exp_q.delete();
                for (int i = 0; i < int'(cmd_len); i++) exp_q.push_back(word_at(cmd_addr + 32'(4 * i)));
                if (cmd_len == '0) done_cyc = cyc + 1;
            end
            if (ar_hs) begin
`ifdef MM2S_ERR_ABORT_EN
                check("no_ar_after_err", err_seen, 0);
`endif
                addr_log.push_back(raddr);
                pend_q.push_back('{raddr, cyc + lat});
                issued++;
            end
            if (m_hs) begin
                if (exp_q.size() == 0) begin
                    check("stream_extra_word", m_data, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("m_data", m_data, e);
                    check("m_last", m_last, exp_q.size() == 0);
                end
                streamed++;
                last_data = m_data;
                if (m_last) done_cyc = cyc + 1;
            end
            if (r_hs) begin
                pend_q.delete(0);
                if (rresp != 2'b00) begin
                    err_seen = 1;
`ifdef MM2S_ERR_ABORT_EN
                    while (exp_q.size() > issued - streamed) void'(exp_q.pop_back());
`endif
                end
                resp_idx++;
            end
            prev_ar_pend = arvalid && !arready;
            prev_raddr   = raddr;
            ar8 = arvalid8 && arready8;
            m8  = m_valid8 && m_ready8;
            if (cmd8_valid && cmd8_ready) got_accept8 = 1;
            if (ar8) log8.push_back(raddr8);
            if (m8) begin
                d8.push_back(m_data8[7:0]);
                l8.push_back(m_last8);
            end
            nxt8_v = ar8;
            nxt8_a = raddr8;
        end
        @(negedge clk);
        cyc++;
        if (rst) begin
            pend_q.delete();
            exp_q.delete();
            done_cyc     = -10;
            accept_cyc   = -10;
            prev_ar_pend = 0;
            nxt8_v       = 0;
            rvalid       = 0;
            rdata        = '0;
            rresp        = 2'b00;
            rvalid8      = 0;
        end else begin
            check("done", done, cyc == done_cyc);
            if (cyc == done_cyc + 1) check("cmd_ready_after_done", cmd_ready, 1);
            if (cyc == accept_cyc + 1) begin
                check("busy_after_accept", busy, 1);
                check("err_cleared_on_accept", err, 0);
                check("first_arvalid", arvalid, cur_len != 0);
            end
            check("credit_limit", (issued - streamed) <= FD, 1);
            if (prev_ar_pend) begin
                check("arvalid_hold", arvalid, 1);
                check("raddr_hold", raddr, prev_raddr);
            end
            arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            m_ready = mr_toggle ? ((cyc / 3) % 2 == 0) : 1'b1;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                rvalid = 1;
                rdata  = word_at(pend_q[0].addr);
                rresp  = (resp_idx == err_word) ? 2'd2 : 2'd0;
            end else begin
                rvalid = 0;
                rdata  = '0;
                rresp  = 2'b00;
            end
            rvalid8 = nxt8_v;
            rdata8  = {24'h0, nxt8_a};
        end
    endtask

    task automatic run_cmd(input logic [31:0] base, input int len);
        cmd_addr   = base;
        cmd_len    = LW'(len);
        cmd_valid  = 1;
        got_accept = 0;
        for (int k = 0; k < 50 && !got_accept; k++) tick();
        cmd_valid = 0;
        if (!got_accept) check("cmd_accept_timeout", 0, 1);
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            tick();
            k++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    // ---------------- stimulus ----------------
    vec_t vecs[5];

    initial begin
        vecs[0] = '{32'h100, 4,  1, 1'b0, 1'b0, -1, 4,  1'b0, 32'hA3};
        vecs[1] = '{32'h200, 16, 6, 1'b1, 1'b1, -1, 16, 1'b0, 32'hEF};
        vecs[2] = '{32'h180, 0,  1, 1'b0, 1'b0, -1, 0,  1'b0, 32'h0};
`ifdef MM2S_ERR_ABORT_EN
        vecs[3] = '{32'h140, 8,  1, 1'b0, 1'b0, 3,  5,  1'b1, 32'hB4};
`else
        vecs[3] = '{32'h140, 8,  1, 1'b0, 1'b0, 3,  8,  1'b1, 32'hB7};
`endif
        vecs[4] = '{32'h120, 2,  2, 1'b0, 1'b0, -1, 2,  1'b0, 32'hA9};

        rst        = 1;
        cmd_addr   = '0;
        cmd_len    = '0;
        cmd_valid  = 0;
        arready    = 1;
        rdata      = '0;
        rresp      = 2'b00;
        rvalid     = 0;
        m_ready    = 1;
        cmd8_addr  = '0;
        cmd8_len   = '0;
        cmd8_valid = 0;
        arready8   = 1;
        rdata8     = '0;
        rresp8     = 2'b00;
        rvalid8    = 0;
        m_ready8   = 1;

        repeat (3) tick();
        check("reset_outputs", {cmd_ready, arvalid, rready, m_valid, m_last, busy, done, err, dbg_state}, 0);
        check("reset_raddr", raddr, 0);
        check("reset_outputs8", {cmd8_ready, arvalid8, rready8, m_valid8, busy8, done8, err8, dbg_state8}, 0);
        rst = 0;
        tick();
        check("cmd_ready_after_reset", cmd_ready, 1);

        // Table-driven commands.
        for (int v = 0; v < 5; v++) begin
            lat       = vecs[v].lat;
            mr_toggle = vecs[v].mr_toggle;
            ar_rand   = vecs[v].ar_rand;
            err_word  = vecs[v].err_word;
            run_cmd(vecs[v].base, vecs[v].len);
            wait_done(3000);
            check("words_streamed", streamed, vecs[v].exp_words);
            check("ar_issued", issued, vecs[v].exp_words);
            check("err_at_done", err, vecs[v].exp_err);
            check("last_word", last_data, vecs[v].exp_last);
            check("scoreboard_empty", exp_q.size(), 0);
            for (int i = 0; i < addr_log.size(); i++)
                check("raddr_seq", addr_log[i], vecs[v].base + 32'(4 * i));
            mr_toggle = 0;
            ar_rand   = 0;
            err_word  = -1;
            tick();
            tick();
        end

        // Address wrap on the 8-bit instance: F8, FC, 00.
        begin
            logic [7:0] exp8 [3];
            exp8[0] = 8'hF8;
            exp8[1] = 8'hFC;
            exp8[2] = 8'h00;
            cmd8_addr   = 8'hF8;
            cmd8_len    = 16'd3;
            cmd8_valid  = 1;
            got_accept8 = 0;
            for (int k = 0; k < 50 && !got_accept8; k++) tick();
            cmd8_valid = 0;
            for (int k = 0; k < 100 && !done8; k++) tick();
            check("wrap_done", done8, 1);
            check("wrap_ar_count", log8.size(), 3);
            check("wrap_word_count", d8.size(), 3);
            for (int i = 0; i < 3 && i < log8.size(); i++) check("wrap_raddr", log8[i], exp8[i]);
            for (int i = 0; i < 3 && i < d8.size(); i++) begin
                check("wrap_data", d8[i], exp8[i]);
                check("wrap_last", l8[i], i == 2);
            end
            tick();
        end

        // Reset in the middle of a 10-word read, then a short command.
        lat = 1;
        run_cmd(32'h300, 10);
        for (int k = 0; k < 200 && streamed < 5 && !done; k++) tick();
        check("midrun_reached_word5", streamed >= 5, 1);
        rst = 1;
        tick();
        check("midrun_reset_outputs", {cmd_ready, arvalid, rready, m_valid, m_last, busy, done, err, dbg_state}, 0);
        check("midrun_reset_raddr", raddr, 0);
        rst = 0;
        tick();
        check("cmd_ready_after_midrun_reset", cmd_ready, 1);
        run_cmd(32'h100, 2);
        wait_done(200);
        check("post_reset_words", streamed, 2);
        check("post_reset_last", last_data, 32'hA1);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
